ioctl_rom_router: RTL

Parametrised ROM-download router that generalises the fixed per-chip ioctl chip-select decode and index filtering of the game top levels. It sits between the MiSTer ioctl download bus and a board's ROM/bank blocks. It filters writes by ioctl index and decodes addresses into NUM_REGIONS regions, each defined by a base and a size. It emits registered per-region write strobes with region-local addresses, counts bytes per region, tracks load completion, and holds the CPU in reset until the load succeeds.

---
 rtl/ioctl_rom_router_if.sv | 27 ++
 rtl/ioctl_rom_router.sv | 135 +++++++++++++
 2 files changed

// File: rtl/ioctl_rom_router_if.sv
// ioctl download bus bundle for the ROM router.
// Master drives the bus; the router samples it as slave.
interface ioctl_rom_router_if #(
  parameter int AW = 25
);
  logic          ioctl_download;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_data;

  modport master (
    output ioctl_download,
    output ioctl_index,
    output ioctl_wr,
    output ioctl_addr,
    output ioctl_data
  );

  modport slave (
    input ioctl_download,
    input ioctl_index,
    input ioctl_wr,
    input ioctl_addr,
    input ioctl_data
  );
endinterface

// File: rtl/ioctl_rom_router.sv
// ROM download router: index filter, region decode, byte counting.
// Holds the CPU in reset until every required region is fully loaded.
module ioctl_rom_router #(
  parameter int NUM_REGIONS = 15,
  parameter int AW = 25,
  parameter int LAW = 16,
  parameter logic [NUM_REGIONS*AW-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS*AW-1:0] REGION_SIZE = '0,
  parameter logic [NUM_REGIONS-1:0] REQUIRED_MASK = '1,
  parameter logic [7:0] INDEX_VAL = 8'd0
) (
  input  logic                   clk_49m,
  input  logic                   reset,
  ioctl_rom_router_if.slave      ioctl,
  output logic [NUM_REGIONS-1:0] rom_we,
  output logic [LAW-1:0]         rom_addr,
  output logic [7:0]             rom_data,
  output logic [NUM_REGIONS-1:0] region_loaded,
  output logic                   all_loaded,
  output logic                   err_unmapped,
  output logic                   cpu_hold,
  output logic                   busy
);
  localparam int N = NUM_REGIONS;
  localparam logic [AW-1:0] ONE = AW'(1);

  typedef enum logic [2:0] {
    IDLE, LOAD, CHECK, DONE, ERROR
  } state_t;

  state_t        state;
  logic          dl_q;
  logic [AW-1:0] cnt [N];

  logic          idx_ok;
  logic          accept;
  logic          rise;
  logic [N-1:0]  hit;
  logic [N-1:0]  pick;
  logic [N-1:0]  full;
  logic [AW-1:0] pick_base;

  assign idx_ok = ioctl.ioctl_index == INDEX_VAL;
  assign rise   = ioctl.ioctl_download & ~dl_q;
  assign accept = ioctl.ioctl_wr & ioctl.ioctl_download
                & idx_ok & (state == LOAD);

  // Range decode in AW+1 bits; lowest index wins on overlap.
  always_comb begin
    hit       = '0;
    full      = '0;
    pick_base = '0;
    for (int i = 0; i < N; i++) begin
      hit[i] = (REGION_SIZE[i*AW +: AW] != '0)
             && ({1'b0, ioctl.ioctl_addr}
                 >= {1'b0, REGION_BASE[i*AW +: AW]})
             && ({1'b0, ioctl.ioctl_addr}
                 < ({1'b0, REGION_BASE[i*AW +: AW]}
                  + {1'b0, REGION_SIZE[i*AW +: AW]}));
      full[i] = (REGION_SIZE[i*AW +: AW] != '0)
              && (cnt[i] == REGION_SIZE[i*AW +: AW]);
    end
    pick = hit & (-hit);
    for (int i = 0; i < N; i++) begin
      if (pick[i]) pick_base |= REGION_BASE[i*AW +: AW];
    end
  end

  // Load FSM, write strobes, counters and status outputs.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      dl_q          <= 1'b0;
      rom_we        <= '0;
      rom_addr      <= '0;
      rom_data      <= '0;
      region_loaded <= '0;
      all_loaded    <= 1'b0;
      err_unmapped  <= 1'b0;
      cpu_hold      <= 1'b1;
      busy          <= 1'b0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      dl_q   <= ioctl.ioctl_download;
      rom_we <= '0;
      if (accept) begin
        rom_we   <= pick;
        rom_addr <= LAW'(ioctl.ioctl_addr - pick_base);
        rom_data <= ioctl.ioctl_data;
        if (pick == '0) err_unmapped <= 1'b1;
        for (int i = 0; i < N; i++) begin
          if (pick[i] && cnt[i] != REGION_SIZE[i*AW +: AW])
            cnt[i] <= cnt[i] + ONE;
        end
      end
      case (state)
        IDLE: begin
          if (ioctl.ioctl_download && idx_ok) begin
            state         <= LOAD;
            busy          <= 1'b1;
            region_loaded <= '0;
            err_unmapped  <= 1'b0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
          end
        end
        LOAD: begin
          if (!ioctl.ioctl_download) state <= CHECK;
        end
        CHECK: begin
          region_loaded <= full;
          busy          <= 1'b0;
          if ((full & REQUIRED_MASK) == REQUIRED_MASK) begin
            state      <= DONE;
            all_loaded <= 1'b1;
            cpu_hold   <= 1'b0;
          end else begin
            state <= ERROR;
          end
        end
        DONE, ERROR: begin
          if (rise && idx_ok) begin
            state         <= LOAD;
            busy          <= 1'b1;
            all_loaded    <= 1'b0;
            cpu_hold      <= 1'b1;
            region_loaded <= '0;
            err_unmapped  <= 1'b0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
